// File: rtl/jtframe_hexentry.sv
// Hex editor input front end: turns debounced button/joystick actions into a
// nibble-by-nibble edited word, with auto-repeat on directions and commit to a held value.
module jtframe_hexentry #(
  parameter int unsigned LENBYTES    = 8,
  parameter int unsigned REPEAT_DLY  = 24,
  parameter int unsigned REPEAT_RATE = 6,
  localparam int unsigned W   = LENBYTES * 8,
  localparam int unsigned NIB = 2 * LENBYTES,
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          enable,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_ok,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  output logic [W-1:0]  data,
  output logic [W-1:0]  work,
  output logic [CW-1:0] cursor,
  output logic          editing,
  output logic          commit
);

  localparam int unsigned B_DOWN  = 0;
  localparam int unsigned B_UP    = 1;
  localparam int unsigned B_RIGHT = 2;
  localparam int unsigned B_LEFT  = 3;
  localparam int unsigned B_OK    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  logic [4:0]    btn_q, btn_prev_q;
  logic          vs_q, vs_prev_q;
  logic [3:0]    rep_dir_q, rep_dir_d;
  logic [7:0]    rep_cnt_q, rep_cnt_d;
  logic          rep_on_q, rep_on_d;
  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  work_q, work_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          editing_q;
  logic          commit_q, commit_d;

  logic [4:0]    edge_c, ev_c;
  logic          frame_c, held_c, rep_tick_c;
  logic [7:0]    rep_tgt_c;
  logic [3:0]    cur_nib_c, nib_new_c;
  logic          nib_wr_c;

  assign edge_c    = btn_q & ~btn_prev_q;
  assign frame_c   = vs_q & ~vs_prev_q;
  assign held_c    = |(rep_dir_q & btn_q[3:0]);
  assign rep_tgt_c = rep_on_q ? 8'(REPEAT_RATE) : 8'(REPEAT_DLY);
  assign ev_c      = {edge_c[B_OK], edge_c[3:0] | (rep_tick_c ? rep_dir_q : 4'b0000)};

  // Shared auto-repeat timer: tracks the most recent direction edge in frames
  always_comb begin
    rep_dir_d  = rep_dir_q;
    rep_cnt_d  = rep_cnt_q;
    rep_on_d   = rep_on_q;
    rep_tick_c = 1'b0;
    if (|edge_c[3:0]) begin
      rep_cnt_d = 8'd0;
      rep_on_d  = 1'b0;
      if (edge_c[B_LEFT])       rep_dir_d = 4'b1000;
      else if (edge_c[B_RIGHT]) rep_dir_d = 4'b0100;
      else if (edge_c[B_UP])    rep_dir_d = 4'b0010;
      else                      rep_dir_d = 4'b0001;
    end else if (!held_c) begin
      rep_dir_d = 4'b0000;
      rep_cnt_d = 8'd0;
      rep_on_d  = 1'b0;
    end else if (frame_c) begin
      if (rep_cnt_q + 8'd1 == rep_tgt_c) begin
        rep_tick_c = 1'b1;
        rep_cnt_d  = 8'd0;
        rep_on_d   = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    cur_nib_c = 4'd0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (cursor_q == CW'(k)) cur_nib_c = work_q[W-1-4*k -: 4];
    end
  end

  // Edit state machine; only the highest-priority event acts each cycle
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    work_d    = work_q;
    cursor_d  = cursor_q;
    commit_d  = 1'b0;
    nib_wr_c  = 1'b0;
    nib_new_c = cur_nib_c;
    case (state_q)
      S_IDLE: begin
        if (load) data_d = load_data;
        work_d = data_d;
        if (ev_c[B_OK] && enable) begin
          state_d  = S_EDIT;
          cursor_d = '0;
        end
      end
      S_EDIT: begin
        if (!enable) begin
          state_d = S_IDLE;
          work_d  = data_q;
        end else if (ev_c[B_OK]) begin
          state_d  = S_COMMIT;
          data_d   = work_q;
          commit_d = 1'b1;
        end else if (ev_c[B_LEFT]) begin
          cursor_d = (cursor_q == '0) ? CW'(NIB - 1) : cursor_q - CW'(1);
        end else if (ev_c[B_RIGHT]) begin
          cursor_d = (cursor_q == CW'(NIB - 1)) ? '0 : cursor_q + CW'(1);
        end else if (ev_c[B_UP]) begin
          nib_wr_c  = 1'b1;
          nib_new_c = cur_nib_c + 4'd1;
        end else if (ev_c[B_DOWN]) begin
          nib_wr_c  = 1'b1;
          nib_new_c = cur_nib_c - 4'd1;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (nib_wr_c) begin
      for (int unsigned k = 0; k < NIB; k++) begin
        if (cursor_q == CW'(k)) work_d[W-1-4*k -: 4] = nib_new_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q      <= 5'd0;
      btn_prev_q <= 5'd0;
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      rep_dir_q  <= 4'd0;
      rep_cnt_q  <= 8'd0;
      rep_on_q   <= 1'b0;
      state_q    <= S_IDLE;
      data_q     <= '0;
      work_q     <= '0;
      cursor_q   <= '0;
      editing_q  <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      btn_q      <= {btn_ok, btn_left, btn_right, btn_up, btn_down};
      btn_prev_q <= btn_q;
      vs_q       <= vs;
      vs_prev_q  <= vs_q;
      rep_dir_q  <= rep_dir_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_on_q   <= rep_on_d;
      state_q    <= state_d;
      data_q     <= data_d;
      work_q     <= work_d;
      cursor_q   <= cursor_d;
      editing_q  <= (state_d == S_EDIT);
      commit_q   <= commit_d;
    end
  end

  assign data    = data_q;
  assign work    = work_q;
  assign cursor  = cursor_q;
  assign editing = editing_q;
  assign commit  = commit_q;

endmodule

// File: tb/tb_jtframe_hexentry.sv
// Bench for jtframe_hexentry: directed vector table, auto-repeat and reset
// sequences, then random stimulus against a frame/nibble-level reference model.
module tb_jtframe_hexentry;

  localparam int unsigned NIB  = 16;
  localparam int          DLY  = 24;
  localparam int          RATE = 6;

  logic        clk = 1'b0;
  logic        rst_n, vs, enable, load;
  logic        btn_left, btn_right, btn_up, btn_down, btn_ok;
  logic [63:0] load_data;
  logic [63:0] data, work;
  logic [3:0]  cursor;
  logic        editing, commit;

  always #5 clk = ~clk;

  jtframe_hexentry #(.LENBYTES(8), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .enable(enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_ok(btn_ok), .load(load), .load_data(load_data),
    .data(data), .work(work), .cursor(cursor), .editing(editing), .commit(commit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  m_btn, m_prev;   // {ok,left,right,up,down}
  logic        m_vs, m_vs_prev;
  int          m_dir, m_frames, m_mode, m_cur;  // mode: 0 idle, 1 edit, 2 commit
  logic [63:0] m_data;
  logic [3:0]  m_nib[NIB];
  logic        m_edit, m_commit;

  function automatic logic [63:0] m_work();
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < NIB; k++) w[63-4*k -: 4] = m_nib[k];
    return w;
  endfunction

  task automatic m_nibs_from_data();
    for (int k = 0; k < NIB; k++) m_nib[k] = m_data[63-4*k -: 4];
  endtask

  task automatic model_step();
    logic [4:0] cur_in, edges, ev;
    logic       frame;
    int         act;
    cur_in = {btn_ok, btn_left, btn_right, btn_up, btn_down};
    if (!rst_n) begin
      m_btn = 0; m_prev = 0; m_vs = 0; m_vs_prev = 0;
      m_dir = -1; m_frames = 0; m_mode = 0; m_cur = 0;
      m_data = 0; m_nibs_from_data();
      m_edit = 0; m_commit = 0;
      return;
    end
    edges = m_btn & ~m_prev;
    frame = m_vs & ~m_vs_prev;
    ev    = edges;
    if (|edges[3:0]) begin
      for (int b = 3; b >= 0; b--) if (edges[b]) begin m_dir = b; break; end
      m_frames = 0;
    end else if (m_dir >= 0 && !m_btn[m_dir]) begin
      m_dir = -1;
    end else if (m_dir >= 0 && frame) begin
      m_frames++;
      if (m_frames == DLY || (m_frames > DLY && (m_frames - DLY) % RATE == 0)) ev[m_dir] = 1'b1;
    end
    act = -1;
    for (int b = 4; b >= 0; b--) if (ev[b]) begin act = b; break; end
    m_commit = 0;
    case (m_mode)
      0: begin
        if (load) m_data = load_data;
        m_nibs_from_data();
        if (act == 4 && enable) begin m_mode = 1; m_cur = 0; end
      end
      1: begin
        if (!enable) begin
          m_mode = 0; m_nibs_from_data();
        end else begin
          case (act)
            4: begin m_mode = 2; m_data = m_work(); m_commit = 1; end
            3: m_cur = (m_cur + NIB - 1) % NIB;
            2: m_cur = (m_cur + 1) % NIB;
            1: m_nib[m_cur] = m_nib[m_cur] + 4'd1;
            0: m_nib[m_cur] = m_nib[m_cur] - 4'd1;
            default: ;
          endcase
        end
      end
      default: m_mode = 0;
    endcase
    m_edit    = (m_mode == 1);
    m_prev    = m_btn;
    m_btn     = cur_in;
    m_vs_prev = m_vs;
    m_vs      = vs;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_ok, btn_left, btn_right, btn_up, btn_down} = b;
  endtask

  task automatic check_outs(input string tag, input logic [63:0] ed, ew,
                            input logic [3:0] ec, input logic ee, ecm);
    check({tag, ".data"},    data,          ed);
    check({tag, ".work"},    work,          ew);
    check({tag, ".cursor"},  64'(cursor),   64'(ec));
    check({tag, ".editing"}, 64'(editing),  64'(ee));
    check({tag, ".commit"},  64'(commit),   64'(ecm));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  btn;
    logic        en, ld;
    logic [63:0] ld_data, e_data, e_work;
    logic [3:0]  e_cur;
    logic        e_edit, e_commit;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] b, input logic en, ld,
                              input logic [63:0] ldd, ed, ew,
                              input logic [3:0] ec, input logic ee, ecm);
    vec_t v;
    v.btn = b; v.en = en; v.ld = ld; v.ld_data = ldd;
    v.e_data = ed; v.e_work = ew; v.e_cur = ec; v.e_edit = ee; v.e_commit = ecm;
    return v;
  endfunction

  localparam logic [63:0] VA = 64'h0123456789ABCDEF;
  localparam logic [63:0] VB = 64'h3123456789ABCDEF;
  localparam logic [63:0] VC = 64'h3123456789ABCDE0;
  localparam logic [63:0] VD = 64'h2123456789ABCDE0;

  vec_t vecs[18];

  initial begin
    logic [4:0] rb;
    vecs[0]  = mk(5'b00000, 1, 1, VA, VA, VA, 0, 0, 0);   // load in idle
    vecs[1]  = mk(5'b10000, 1, 0, 0, VA, VA, 0, 1, 0);    // enter edit
    vecs[2]  = mk(5'b00010, 1, 0, 0, VA, 64'h1123456789ABCDEF, 0, 1, 0);
    vecs[3]  = mk(5'b00010, 1, 0, 0, VA, 64'h2123456789ABCDEF, 0, 1, 0);
    vecs[4]  = mk(5'b00010, 1, 0, 0, VA, VB, 0, 1, 0);
    vecs[5]  = mk(5'b10000, 1, 0, 0, VB, VB, 0, 0, 1);    // commit
    vecs[6]  = mk(5'b10000, 1, 0, 0, VB, VB, 0, 1, 0);
    vecs[7]  = mk(5'b01000, 1, 0, 0, VB, VB, 15, 1, 0);   // left wraps
    vecs[8]  = mk(5'b00010, 1, 0, 0, VB, VC, 15, 1, 0);   // F -> 0
    vecs[9]  = mk(5'b00100, 1, 0, 0, VB, VC, 0, 1, 0);    // right wraps
    vecs[10] = mk(5'b00001, 1, 0, 0, VB, VD, 0, 1, 0);
    vecs[11] = mk(5'b10010, 1, 0, 0, VD, VD, 0, 0, 1);    // ok beats up
    vecs[12] = mk(5'b10000, 1, 0, 0, VD, VD, 0, 1, 0);
    vecs[13] = mk(5'b01100, 1, 0, 0, VD, VD, 15, 1, 0);   // left beats right
    vecs[14] = mk(5'b00100, 1, 0, 0, VD, VD, 0, 1, 0);
    vecs[15] = mk(5'b00010, 1, 0, 0, VD, VC, 0, 1, 0);
    vecs[16] = mk(5'b00000, 0, 0, 0, VD, VD, 0, 0, 0);    // abort
    vecs[17] = mk(5'b10000, 0, 0, 0, VD, VD, 0, 0, 0);    // ok ignored when disabled

    rst_n = 0; vs = 0; enable = 0; load = 0; load_data = '0; set_btn(0);
    tick(); tick();
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      set_btn(vecs[i].btn); enable = vecs[i].en; load = vecs[i].ld; load_data = vecs[i].ld_data;
      tick();
      set_btn(0); load = 0;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_work,
                 vecs[i].e_cur, vecs[i].e_edit, vecs[i].e_commit);
    end

    // auto-repeat on held down, nibble 0 starts at 0
    enable = 1; load = 1; load_data = VA;
    tick(); load = 0;
    set_btn(5'b10000); tick(); set_btn(0); tick();
    check("rep.editing", 64'(editing), 64'd1);
    set_btn(5'b00001); tick(); tick();
    check("rep.press", work, 64'hF123456789ABCDEF);
    for (int f = 1; f <= 40; f++) begin
      vs = 1; tick(); tick();
      vs = 0; tick(); tick();
      if (f == 23) check("rep.f23", work, 64'hF123456789ABCDEF);
      if (f == 24) check("rep.f24", work, 64'hE123456789ABCDEF);
      if (f == 30) check("rep.f30", work, 64'hD123456789ABCDEF);
      if (f == 40) check("rep.f40", work, 64'hC123456789ABCDEF);
    end
    check("rep.data", data, VA);
    set_btn(0); tick(); tick();

    // reset while editing discards everything
    check("pre_rst.editing", 64'(editing), 64'd1);
    rst_n = 0; tick(); tick();
    check_outs("midrst", 0, 0, 0, 0, 0);
    rst_n = 1; tick();

    // random stimulus against the reference model
    rb = 0; enable = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      vs = ((cyc % 8) < 4);
      for (int b = 0; b < 5; b++) if ($urandom_range(149) == 0) rb[b] = ~rb[b];
      set_btn(rb);
      if (enable && $urandom_range(299) == 0) enable = 0;
      else if (!enable && $urandom_range(19) == 0) enable = 1;
      load = ($urandom_range(39) == 0);
      load_data = {$urandom, $urandom};
      rst_n = ($urandom_range(999) != 0);
      tick();
      check_outs("rand", m_data, m_work(), 4'(m_cur), m_edit, m_commit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
